// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg
//   Shared definitions for the frame strobe sequencer:
//   - state_e        : sequencer FSM states (IDLE / STROBE / GAP)
//   - BROADCAST_COL  : all-ones column code, sliced to the column address width at use
//   - frame_idx_w()  : width of the frame index for a given frames-per-column count
//   - cnt_w()        : width of the strobe/gap down-counter
package frame_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_e;

    // Kept wide so any column address width can take its low bits.
    localparam logic [31:0] BROADCAST_COL = 32'hFFFF_FFFF;

    function automatic int unsigned frame_idx_w(input int unsigned max_frames);
        return (max_frames > 1) ? $clog2(max_frames) : 1;
    endfunction

    // Counter must be able to hold max(StrobeCycles, GapCycles).
    function automatic int unsigned cnt_w(input int unsigned s, input int unsigned g);
        int unsigned m;
        m = (s > g) ? s : g;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/frame_strobe_decode.sv
// frame_strobe_decode
//   Combinational decode of a (column, frame) pair into the flattened
//   per-column one-hot strobe bus. Column c owns bits
//   [c*MaxFramesPerCol +: MaxFramesPerCol]. The all-ones column code
//   selects every column.
// Ports:
//   en_i      : when low the whole bus is zero
//   col_i     : column address (all-ones = broadcast)
//   frame_i   : frame index within the column
//   strobe_o  : NumCols*MaxFramesPerCol strobe bus
module frame_strobe_decode
    import frame_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5,
    parameter int unsigned NumCols          = 15,
    localparam int unsigned FrameIdxW       = frame_idx_w(MaxFramesPerCol)
) (
    input  logic                                  en_i,
    input  logic [FrameSelectWidth-1:0]           col_i,
    input  logic [FrameIdxW-1:0]                  frame_i,
    output logic [NumCols*MaxFramesPerCol-1:0]    strobe_o
);

    localparam logic [FrameSelectWidth-1:0] BcastCol = BROADCAST_COL[FrameSelectWidth-1:0];

    logic bcast;
    assign bcast = (col_i == BcastCol);

    always_comb begin
        strobe_o = '0;
        for (int c = 0; c < NumCols; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                strobe_o[c*MaxFramesPerCol + f] = en_i
                    && (frame_i == FrameIdxW'(f))
                    && (bcast || (col_i == FrameSelectWidth'(c)));
            end
        end
    end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer
//   Accepts (column, frame) write requests over valid/ready and drives a
//   registered one-hot frame strobe into the addressed column (or all
//   columns for the broadcast code) for StrobeCycles cycles, then idles
//   for GapCycles before accepting again. Out-of-range requests are
//   dropped and flagged with a one-cycle err pulse.
// Ports:
//   CLK, resetn     : clock (rising edge), asynchronous active-low reset
//   req_valid/ready : request handshake; ready only in IDLE
//   req_col         : target column, all-ones = broadcast
//   req_frame       : frame index within the column
//   FrameStrobe_O   : per-column one-hot strobes, column c at [c*MaxFramesPerCol +: MaxFramesPerCol]
//   busy            : high while in STROBE or GAP
//   err             : one-cycle pulse after a rejected request
module frame_strobe_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5,
    parameter int unsigned NumCols          = 15,
    parameter int unsigned StrobeCycles     = 1,
    parameter int unsigned GapCycles        = 1,
    localparam int unsigned FrameIdxW       = frame_idx_w(MaxFramesPerCol)
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [FrameSelectWidth-1:0]        req_col,
    input  logic [FrameIdxW-1:0]               req_frame,
    output logic [NumCols*MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                               busy,
    output logic                               err
);

    localparam int unsigned CntW = cnt_w(StrobeCycles, GapCycles);
    localparam int unsigned OutW = NumCols * MaxFramesPerCol;

    localparam logic [CntW-1:0] StrobeLoad = CntW'(StrobeCycles - 1);
    localparam logic [CntW-1:0] GapLoad    = CntW'((GapCycles > 0) ? (GapCycles - 1) : 0);

    localparam logic [FrameSelectWidth-1:0] BcastCol  = BROADCAST_COL[FrameSelectWidth-1:0];
    localparam logic [FrameSelectWidth-1:0] NumColsV  = FrameSelectWidth'(NumCols);
    // One extra bit so a power-of-two frame count still compares correctly.
    localparam logic [FrameIdxW:0]          MaxFramesV = (FrameIdxW + 1)'(MaxFramesPerCol);

    state_e                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [FrameSelectWidth-1:0] col_q, col_d;
    logic [FrameIdxW-1:0]        frame_q, frame_d;
    logic                        err_q, err_d;
    logic [OutW-1:0]             strobe_q, strobe_d;

    logic accept;
    logic req_ok;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_ok    = ({1'b0, req_frame} < MaxFramesV)
                       && ((req_col < NumColsV) || (req_col == BcastCol));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        frame_d = frame_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_ok) begin
                        state_d = STROBE;
                        cnt_d   = StrobeLoad;
                        col_d   = req_col;
                        frame_d = req_frame;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (GapCycles == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GapLoad;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode from next-state so the strobe register lines up with the
    // STROBE state and the output comes straight off flops.
    frame_strobe_decode #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .FrameSelectWidth(FrameSelectWidth),
        .NumCols         (NumCols)
    ) u_decode (
        .en_i    (state_d == STROBE),
        .col_i   (col_d),
        .frame_i (frame_d),
        .strobe_o(strobe_d)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            col_q    <= '0;
            frame_q  <= '0;
            err_q    <= 1'b0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
        end
    end

    assign FrameStrobe_O = strobe_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Testbench for frame_strobe_sequencer. Four instances with different
// strobe/gap timings share one stimulus stream; each is compared every
// cycle against a timeline model (accept time + arithmetic), and the
// default-timing instance is additionally checked against a vector table.
module tb_frame_strobe_sequencer;

    localparam int M   = 20;
    localparam int NC  = 15;
    localparam int W   = NC * M;
    localparam int NI  = 4;
    localparam int SC [NI] = '{1, 3, 1, 4};
    localparam int GC [NI] = '{1, 1, 0, 0};

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic [4:0]    req_col = '0;
    logic [4:0]    req_frame = '0;
    logic [NI-1:0] rdy, bsy, er;
    logic [W-1:0]  fs [NI];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        frame_strobe_sequencer #(
            .MaxFramesPerCol (M),
            .FrameSelectWidth(5),
            .NumCols         (NC),
            .StrobeCycles    (SC[g]),
            .GapCycles       (GC[g])
        ) u_dut (
            .CLK          (CLK),
            .resetn       (resetn),
            .req_valid    (req_valid),
            .req_ready    (rdy[g]),
            .req_col      (req_col),
            .req_frame    (req_frame),
            .FrameStrobe_O(fs[g]),
            .busy         (bsy[g]),
            .err          (er[g])
        );
    end

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;

    // Model: per instance, the edge index of the last accepted write and of
    // the last rejected request.
    int acc_t [NI];
    int err_t [NI];
    int acc_col [NI];
    int acc_fr [NI];

    function automatic logic [W-1:0] pattern(input int col, input int fr);
        logic [W-1:0] p;
        p = '0;
        for (int c = 0; c < NC; c++)
            if (col == 31 || col == c) p[c*M + fr] = 1'b1;
        return p;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            acc_t[i] = -1000; err_t[i] = -1000; acc_col[i] = 0; acc_fr[i] = 0;
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < NI; i++) begin
            int d;
            logic [W-1:0] es;
            logic eb;
            d  = cyc - acc_t[i];
            es = (d >= 0 && d < SC[i]) ? pattern(acc_col[i], acc_fr[i]) : '0;
            eb = (d >= 0 && d < SC[i] + GC[i]);
            chk($sformatf("m%0d strobe c%0d", i, cyc), fs[i], es);
            chk($sformatf("m%0d busy c%0d", i, cyc), W'(bsy[i]), W'(eb));
            chk($sformatf("m%0d ready c%0d", i, cyc), W'(rdy[i]), W'(!eb));
            chk($sformatf("m%0d err c%0d", i, cyc), W'(er[i]), W'(err_t[i] == cyc));
        end
    endtask

    // Predict the coming edge from current inputs, clock it, check at negedge.
    task automatic cycle();
        int k;
        k = cyc + 1;
        if (!resetn) begin
            model_reset();
        end else if (req_valid) begin
            for (int i = 0; i < NI; i++) begin
                if (k >= acc_t[i] + SC[i] + GC[i] + 1) begin
                    if (int'(req_frame) < M && (int'(req_col) < NC || int'(req_col) == 31)) begin
                        acc_t[i] = k; acc_col[i] = int'(req_col); acc_fr[i] = int'(req_frame);
                    end else begin
                        err_t[i] = k;
                    end
                end
            end
        end
        @(posedge CLK);
        cyc = k;
        @(negedge CLK);
        check_model();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int j = 0; j < n; j++) cycle();
    endtask

    typedef struct {
        bit v; int col; int fr;
        bit rdy; bit bsy; bit err; bit on; int ecol; int efr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Expected outputs of the default instance (1 strobe, 1 gap) after each edge.
        tbl[0]  = '{1, 3, 7,   0, 1, 0,  1, 3, 7};
        tbl[1]  = '{0, 0, 0,   0, 1, 0,  0, 0, 0};
        tbl[2]  = '{0, 0, 0,   1, 0, 0,  0, 0, 0};
        tbl[3]  = '{1, 15, 2,  1, 0, 1,  0, 0, 0};
        tbl[4]  = '{1, 0, 20,  1, 0, 1,  0, 0, 0};
        tbl[5]  = '{0, 0, 0,   1, 0, 0,  0, 0, 0};
        tbl[6]  = '{1, 31, 0,  0, 1, 0,  1, 31, 0};
        tbl[7]  = '{1, 3, 1,   0, 1, 0,  0, 0, 0};
        tbl[8]  = '{1, 3, 1,   1, 0, 0,  0, 0, 0};
        tbl[9]  = '{1, 3, 1,   0, 1, 0,  1, 3, 1};
        tbl[10] = '{0, 0, 0,   0, 1, 0,  0, 0, 0};
        tbl[11] = '{0, 0, 0,   1, 0, 0,  0, 0, 0};

        model_reset();
        resetn = 1'b0;
        req_valid = 1'b1;       // ignored while in reset
        req_col = 5'd3; req_frame = 5'd7;
        cycle();
        cycle();
        req_valid = 1'b0;
        resetn = 1'b1;
        idle(1);

        // Table vectors.
        for (int j = 0; j < 12; j++) begin
            req_valid = tbl[j].v;
            req_col   = 5'(tbl[j].col);
            req_frame = 5'(tbl[j].fr);
            cycle();
            chk($sformatf("tbl%0d strobe", j), fs[0], tbl[j].on ? pattern(tbl[j].ecol, tbl[j].efr) : '0);
            chk($sformatf("tbl%0d ready", j), W'(rdy[0]), W'(tbl[j].rdy));
            chk($sformatf("tbl%0d busy", j), W'(bsy[0]), W'(tbl[j].bsy));
            chk($sformatf("tbl%0d err", j), W'(er[0]), W'(tbl[j].err));
        end
        idle(8);

        // Broadcast on the 3-cycle-strobe instance.
        req_valid = 1'b1; req_col = 5'd31; req_frame = 5'd0;
        for (int t = 0; t < 5; t++) begin
            cycle();
            req_valid = 1'b0;
            chk($sformatf("bcast strobe t%0d", t), fs[1], (t < 3) ? pattern(31, 0) : '0);
            chk($sformatf("bcast busy t%0d", t), W'(bsy[1]), W'(t < 4));
            chk($sformatf("bcast ready t%0d", t), W'(rdy[1]), W'(t >= 4));
        end
        idle(8);

        // Valid held high with zero gap: accepts every other cycle.
        for (int j = 0; j < 6; j++) begin
            req_valid = 1'b1; req_col = 5'(j); req_frame = 5'(j + 1);
            cycle();
            chk($sformatf("b2b strobe j%0d", j), fs[2], (j % 2 == 0) ? pattern(j, j + 1) : '0);
        end
        idle(8);

        // Reset in the middle of a 4-cycle strobe.
        req_valid = 1'b1; req_col = 5'd5; req_frame = 5'd9;
        cycle();
        req_valid = 1'b0;
        cycle();
        chk("rst pre strobe", fs[3], pattern(5, 9));
        #2 resetn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst%0d strobe async", i), fs[i], '0);
            chk($sformatf("rst%0d busy async", i), W'(bsy[i]), W'(0));
            chk($sformatf("rst%0d ready async", i), W'(rdy[i]), W'(1));
            chk($sformatf("rst%0d err async", i), W'(er[i]), W'(0));
        end
        model_reset();
        cycle();
        resetn = 1'b1;
        req_valid = 1'b1; req_col = 5'd2; req_frame = 5'd19;
        cycle();
        chk("post rst strobe", fs[3], pattern(2, 19));
        idle(8);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            resetn    = ($urandom_range(0, 99) != 0);
            req_valid = ($urandom_range(0, 99) < 60);
            req_col   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 16));
            req_frame = 5'($urandom_range(0, 21));
            cycle();
        end
        resetn = 1'b1;
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
